// File: rtl/hpdcache_victim_sel_if.sv
// Request/response bundle between a refill controller and the victim-way selector.
// Signal suffixes are relative to the selector: _i driven by master, _o driven by slave.
interface hpdcache_victim_sel_if #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned LFSR_WIDTH = 8
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [WAYS-1:0]       req_valid_ways_i;
    logic [WAYS-1:0]       req_avail_ways_i;
    logic [LFSR_WIDTH-1:0] lfsr_val_i;
    logic                  lfsr_shift_o;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [WAYS-1:0]       rsp_way_o;
    logic                  rsp_none_o;

    modport master (
        output req_valid_i,
        output req_valid_ways_i,
        output req_avail_ways_i,
        output lfsr_val_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  lfsr_shift_o,
        input  rsp_valid_o,
        input  rsp_way_o,
        input  rsp_none_o
    );

    modport slave (
        input  req_valid_i,
        input  req_valid_ways_i,
        input  req_avail_ways_i,
        input  lfsr_val_i,
        input  rsp_ready_i,
        output req_ready_o,
        output lfsr_shift_o,
        output rsp_valid_o,
        output rsp_way_o,
        output rsp_none_o
    );
endinterface

// File: rtl/hpdcache_victim_sel.sv
// Victim-way selector: prefers an invalid evictable way, otherwise scans forward
// from an LFSR-chosen start way, skipping ways that may not be evicted.
module hpdcache_victim_sel #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned LFSR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hpdcache_victim_sel_if.slave  bus
);

    localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [WAYS-1:0]   avail_q, avail_d;
    logic [WAYS-1:0]   way_q, way_d;
    logic              none_q, none_d;

    logic              req_ready_c;
    logic              handshake_c;
    logic              lfsr_shift_c;
    logic [WAYS-1:0]   free_c;
    logic [WAYS-1:0]   free_low_c;
    logic [WAYS-1:0]   ptr_onehot_c;
    logic [PTR_W-1:0]  lfsr_ptr_c;
    logic              unused_lfsr_hi;

    assign req_ready_c  = (state_q == IDLE) & ~rst_i;
    assign handshake_c  = bus.req_valid_i & req_ready_c;

    // Invalid-and-evictable ways; x & -x isolates the lowest set bit.
    assign free_c       = ~bus.req_valid_ways_i & bus.req_avail_ways_i;
    assign free_low_c   = free_c & (~free_c + WAYS'(1));
    assign ptr_onehot_c = WAYS'(1) << ptr_q;

    // Only the low bits of the LFSR pick the start way.
    assign lfsr_ptr_c     = bus.lfsr_val_i[PTR_W-1:0];
    assign unused_lfsr_hi = ^bus.lfsr_val_i[LFSR_WIDTH-1:PTR_W];

    // Next-state and combinational outputs.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        avail_d      = avail_q;
        way_d        = way_q;
        none_d       = none_q;
        lfsr_shift_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (handshake_c) begin
                    avail_d = bus.req_avail_ways_i;
                    if (free_c != '0) begin
                        way_d   = free_low_c;
                        none_d  = 1'b0;
                        state_d = RSP;
                    end else if (bus.req_avail_ways_i == '0) begin
                        way_d   = '0;
                        none_d  = 1'b1;
                        state_d = RSP;
                    end else begin
                        ptr_d        = lfsr_ptr_c;
                        lfsr_shift_c = 1'b1;
                        state_d      = SCAN;
                    end
                end
            end

            // At least one way is available, so this ends within WAYS cycles.
            SCAN: begin
                if (avail_q[ptr_q]) begin
                    way_d   = ptr_onehot_c;
                    none_d  = 1'b0;
                    state_d = RSP;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end

            RSP: begin
                if (bus.rsp_ready_i) begin
                    way_d   = '0;
                    none_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                way_d   = '0;
                none_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            avail_q <= '0;
            way_q   <= '0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            avail_q <= avail_d;
            way_q   <= way_d;
            none_q  <= none_d;
        end
    end

    assign bus.req_ready_o  = req_ready_c;
    assign bus.lfsr_shift_o = lfsr_shift_c;
    assign bus.rsp_valid_o  = (state_q == RSP);
    assign bus.rsp_way_o    = way_q;
    assign bus.rsp_none_o   = none_q;

endmodule
